// File: rtl/song_sequencer.sv
// Song sequencer: walks a synchronous note ROM and drives a square-wave level and play gate to a PWM DAC.
// Optional build macro SONG_LOOP_EN: the song restarts from address 0 instead of ending.
module song_sequencer #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BEAT_DIV  = 25000,
  parameter logic [15:0] AMPLITUDE = 16'h4000
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [23:0]       rom_data,
  output logic [15:0]       pwm_level,
  output logic              play,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BEAT_W = $clog2(BEAT_DIV);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_PLAY  = 2'd3;

  logic [1:0]        r_state,      w_state_nxt;
  logic [ADDR_W-1:0] r_addr,       w_addr_nxt;
  logic [BEAT_W-1:0] r_beat_cnt,   w_beat_cnt_nxt;
  logic [7:0]        r_beats_left, w_beats_left_nxt;
  logic [15:0]       r_half_cnt,   w_half_cnt_nxt;
  logic [15:0]       r_half_reg,   w_half_reg_nxt;
  logic              r_phase,      w_phase_nxt;
  logic              r_played,     w_played_nxt;
  logic [15:0]       r_pwm,        w_pwm_nxt;
  logic              r_play,       w_play_nxt;
  logic              r_busy,       w_busy_nxt;
  logic              r_done,       w_done_nxt;
  logic              w_end;

  // r_played marks that the first note of this pass was loaded, so the gate opens only then
  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_beat_cnt_nxt   = r_beat_cnt;
    w_beats_left_nxt = r_beats_left;
    w_half_cnt_nxt   = r_half_cnt;
    w_half_reg_nxt   = r_half_reg;
    w_phase_nxt      = r_phase;
    w_played_nxt     = r_played;
    w_pwm_nxt        = r_pwm;
    w_play_nxt       = r_play;
    w_done_nxt       = 1'b0;
    w_end            = 1'b0;

    if (stop) begin
      w_state_nxt  = S_IDLE;
      w_addr_nxt   = '0;
      w_play_nxt   = 1'b0;
      w_pwm_nxt    = '0;
      w_played_nxt = 1'b0;
    end else if (start) begin
      w_state_nxt  = S_FETCH;
      w_addr_nxt   = '0;
      w_play_nxt   = 1'b0;
      w_pwm_nxt    = '0;
      w_played_nxt = 1'b0;
    end else if (r_state == S_IDLE) begin
      w_play_nxt = 1'b0;
      w_pwm_nxt  = '0;
    end else if (pause) begin
      w_play_nxt = 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          w_state_nxt = S_LOAD;
          w_play_nxt  = r_played;
        end
        S_LOAD: begin
          w_play_nxt = r_played;
          if (rom_data[23:16] == 8'd0) begin
            w_end = 1'b1;
          end else begin
            w_state_nxt      = S_PLAY;
            w_beats_left_nxt = rom_data[23:16];
            w_half_reg_nxt   = rom_data[15:0];
            w_beat_cnt_nxt   = '0;
            w_half_cnt_nxt   = '0;
            w_phase_nxt      = 1'b1;
            w_pwm_nxt        = (rom_data[15:0] != 16'd0) ? AMPLITUDE : 16'd0;
            w_play_nxt       = 1'b1;
            w_played_nxt     = 1'b1;
          end
        end
        default: begin
          w_play_nxt = 1'b1;
          if (r_half_reg != 16'd0) begin
            if (r_half_cnt == r_half_reg - 16'd1) begin
              w_half_cnt_nxt = '0;
              w_phase_nxt    = ~r_phase;
            end else begin
              w_half_cnt_nxt = r_half_cnt + 16'd1;
            end
          end
          w_pwm_nxt = (w_phase_nxt && (r_half_reg != 16'd0)) ? AMPLITUDE : 16'd0;
          if (r_beat_cnt == BEAT_W'(BEAT_DIV - 1)) begin
            w_beat_cnt_nxt = '0;
            if (r_beats_left == 8'd1) begin
              if (r_addr == {ADDR_W{1'b1}}) begin
                w_end = 1'b1;
              end else begin
                w_addr_nxt  = r_addr + ADDR_W'(1);
                w_state_nxt = S_FETCH;
              end
            end else begin
              w_beats_left_nxt = r_beats_left - 8'd1;
            end
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + BEAT_W'(1);
          end
        end
      endcase

      if (w_end) begin
        w_done_nxt = 1'b1;
`ifdef SONG_LOOP_EN
        w_state_nxt = S_FETCH;
        w_addr_nxt  = '0;
`else
        w_state_nxt  = S_IDLE;
        w_play_nxt   = 1'b0;
        w_pwm_nxt    = '0;
        w_played_nxt = 1'b0;
`endif
      end
    end

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_beat_cnt   <= '0;
      r_beats_left <= '0;
      r_half_cnt   <= '0;
      r_half_reg   <= '0;
      r_phase      <= 1'b0;
      r_played     <= 1'b0;
      r_pwm        <= '0;
      r_play       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
      r_beats_left <= w_beats_left_nxt;
      r_half_cnt   <= w_half_cnt_nxt;
      r_half_reg   <= w_half_reg_nxt;
      r_phase      <= w_phase_nxt;
      r_played     <= w_played_nxt;
      r_pwm        <= w_pwm_nxt;
      r_play       <= w_play_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  assign rom_addr  = r_addr;
  assign pwm_level = r_pwm;
  assign play      = r_play;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: expected output-change events are queued by the stimulus,
// and a negedge monitor pops one whenever the DUT outputs change. Honours SONG_LOOP_EN.
module tb_song_sequencer;

  localparam int unsigned ADDR_W = 2;
  localparam logic [15:0] AMP    = 16'h4000;

  logic              clk_in = 1'b0;
  logic              reset;
  logic              start, stop, pause;
  logic [ADDR_W-1:0] rom_addr;
  logic [23:0]       rom_data;
  logic [15:0]       pwm_level;
  logic              play, busy, done;

  logic [23:0] rom [4];

  typedef struct packed {
    logic [31:0]       rel;
    logic              play;
    logic [15:0]       pwm;
    logic [ADDR_W-1:0] addr;
    logic              busy;
    logic              done;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  t0 = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;
  logic [20:0] prev_snap;

  song_sequencer #(.ADDR_W(ADDR_W), .BEAT_DIV(4), .AMPLITUDE(AMP)) dut (
    .clk_in(clk_in), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .rom_addr(rom_addr), .rom_data(rom_data), .pwm_level(pwm_level),
    .play(play), .busy(busy), .done(done)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  always @(posedge clk_in) rom_data <= rom[rom_addr];

  // Monitor: every change of the output tuple must match the head of the queue, including its cycle
  always @(negedge clk_in) begin
    logic [20:0] snap;
    ev_t e;
    snap = {play, pwm_level, rom_addr, busy, done};
    if (mon_en && snap != prev_snap) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event rel=%0d got play=%b pwm=%h addr=%0d busy=%b done=%b, required no change",
                 cyc - t0, play, pwm_level, rom_addr, busy, done);
      end else begin
        e = exp_q.pop_front();
        if (e.rel != 32'(cyc - t0) || e.play !== play || e.pwm !== pwm_level ||
            e.addr !== rom_addr || e.busy !== busy || e.done !== done) begin
          n_fail++;
          $display("FAIL event got rel=%0d play=%b pwm=%h addr=%0d busy=%b done=%b, required rel=%0d play=%b pwm=%h addr=%0d busy=%b done=%b",
                   cyc - t0, play, pwm_level, rom_addr, busy, done,
                   e.rel, e.play, e.pwm, e.addr, e.busy, e.done);
        end
      end
    end
    prev_snap = snap;
  end

  task automatic expect_ev(input int rel, input logic pl, input logic [15:0] pw,
                           input logic [ADDR_W-1:0] ad, input logic bz, input logic dn);
    ev_t e;
    e.rel = 32'(rel); e.play = pl; e.pwm = pw; e.addr = ad; e.busy = bz; e.done = dn;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %h required %h", name, got, want);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk_in);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  task automatic wait_rel(input int n);
    while (cyc - t0 < n) @(negedge clk_in);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk_in);
      k++;
    end
    repeat (6) @(negedge clk_in);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout got %0d pending events required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    foreach (rom[i]) rom[i] = 24'h0;
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    check("rst_play", 16'(play), 16'h0);
    check("rst_pwm", pwm_level, 16'h0);
    check("rst_addr", 16'(rom_addr), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_done", 16'(done), 16'h0);
    prev_snap = 21'h0;
    mon_en = 1'b1;

`ifndef SONG_LOOP_EN
    // Tone note (2 beats, half-period 100) then end marker
    rom[0] = 24'h02_0064; rom[1] = 24'h00_0000;
    expect_ev(1, 0, 16'h0, 0, 1, 0);
    expect_ev(3, 1, AMP, 0, 1, 0);
    expect_ev(11, 1, AMP, 1, 1, 0);
    expect_ev(13, 0, 16'h0, 1, 0, 1);
    expect_ev(14, 0, 16'h0, 1, 0, 0);
    pulse_start();
    drain("t1_tone");

    // Rest note of 3 beats
    rom[0] = 24'h03_0000; rom[1] = 24'h00_0000;
    expect_ev(1, 0, 16'h0, 0, 1, 0);
    expect_ev(3, 1, 16'h0, 0, 1, 0);
    expect_ev(15, 1, 16'h0, 1, 1, 0);
    expect_ev(17, 0, 16'h0, 1, 0, 1);
    expect_ev(18, 0, 16'h0, 1, 0, 0);
    pulse_start();
    drain("t2_rest");

    // 50-cycle pause mid-note shifts everything after it by exactly 50 cycles
    rom[0] = 24'h03_0002; rom[1] = 24'h00_0000;
    expect_ev(1, 0, 16'h0, 0, 1, 0);
    expect_ev(3, 1, AMP, 0, 1, 0);
    expect_ev(5, 1, 16'h0, 0, 1, 0);
    expect_ev(6, 0, 16'h0, 0, 1, 0);
    expect_ev(56, 1, 16'h0, 0, 1, 0);
    expect_ev(57, 1, AMP, 0, 1, 0);
    expect_ev(59, 1, 16'h0, 0, 1, 0);
    expect_ev(61, 1, AMP, 0, 1, 0);
    expect_ev(63, 1, 16'h0, 0, 1, 0);
    expect_ev(65, 1, AMP, 1, 1, 0);
    expect_ev(67, 0, 16'h0, 1, 0, 1);
    expect_ev(68, 0, 16'h0, 1, 0, 0);
    pulse_start();
    wait_rel(5);
    pause = 1'b1;
    repeat (50) @(negedge clk_in);
    pause = 1'b0;
    drain("t3_pause");
`endif

    // stop and start together mid-note: stop wins, no done
    rom[0] = 24'h02_0064; rom[1] = 24'h00_0000;
    expect_ev(1, 0, 16'h0, 0, 1, 0);
    expect_ev(3, 1, AMP, 0, 1, 0);
    expect_ev(6, 0, 16'h0, 0, 0, 0);
    pulse_start();
    wait_rel(5);
    stop = 1'b1; start = 1'b1;
    @(negedge clk_in);
    stop = 1'b0; start = 1'b0;
    drain("t4_stop");

    // Asynchronous reset mid-note clears outputs without waiting for a clock
    expect_ev(1, 0, 16'h0, 0, 1, 0);
    expect_ev(3, 1, AMP, 0, 1, 0);
    expect_ev(6, 0, 16'h0, 0, 0, 0);
    pulse_start();
    wait_rel(5);
    #2 reset = 1'b1;
    #1;
    check("areset_play", 16'(play), 16'h0);
    check("areset_pwm", pwm_level, 16'h0);
    check("areset_busy", 16'(busy), 16'h0);
    @(negedge clk_in);
    @(negedge clk_in);
    reset = 1'b0;
    drain("t4_reset");

`ifndef SONG_LOOP_EN
    // Four notes fill the 2-bit address space; song ends at address 3 without wrapping
    foreach (rom[i]) rom[i] = 24'h01_0000;
    expect_ev(1, 0, 16'h0, 0, 1, 0);
    expect_ev(3, 1, 16'h0, 0, 1, 0);
    expect_ev(7, 1, 16'h0, 1, 1, 0);
    expect_ev(13, 1, 16'h0, 2, 1, 0);
    expect_ev(19, 1, 16'h0, 3, 1, 0);
    expect_ev(25, 0, 16'h0, 3, 0, 1);
    expect_ev(26, 0, 16'h0, 3, 0, 0);
    pulse_start();
    drain("t5_full");
`else
    // Looping two-note song: address returns to 0, done per pass, gate never drops
    rom[0] = 24'h01_0000; rom[1] = 24'h01_0000; rom[2] = 24'h00_0000;
    expect_ev(1, 0, 16'h0, 0, 1, 0);
    expect_ev(3, 1, 16'h0, 0, 1, 0);
    expect_ev(7, 1, 16'h0, 1, 1, 0);
    expect_ev(13, 1, 16'h0, 2, 1, 0);
    expect_ev(15, 1, 16'h0, 0, 1, 1);
    expect_ev(16, 1, 16'h0, 0, 1, 0);
    expect_ev(21, 1, 16'h0, 1, 1, 0);
    expect_ev(23, 0, 16'h0, 0, 0, 0);
    pulse_start();
    wait_rel(22);
    stop = 1'b1;
    @(negedge clk_in);
    stop = 1'b0;
    drain("t6_loop");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
